// File: rtl/axi_lite_req_arbiter_if.sv
// rtl/axi_lite_req_arbiter_if.sv - AXI-Lite master bus between the request arbiter and the CSR slave
interface axi_lite_req_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int STRB_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arvalid, input m_arready,
    input m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    input m_awaddr, m_awvalid, output m_awready,
    input m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// rtl/axi_lite_req_arbiter.sv - round-robin arbiter sharing one AXI-Lite master among NUM_REQ requesters
// Optional per-phase abort on a hung slave: define AXI_ARB_TIMEOUT_EN.
module axi_lite_req_arbiter #(
  parameter int DATA_W      = 32,
  parameter int STRB_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int NUM_REQ     = 2,
  parameter int TXN_TIMEOUT = 50
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  output logic                      timeout_pulse,
  axi_lite_req_arbiter_if.master    m
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD_A, RD_D, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     arb_idx;
  logic [GW-1:0]     cand;
  logic              arb_found;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [STRB_W-1:0] lat_wstrb;
  logic              aw_pend;
  logic              w_pend;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              advance;
  logic              abort;

  assign m.m_awaddr  = lat_addr;
  assign m.m_araddr  = lat_addr;
  assign m.m_wdata   = lat_wdata;
  assign m.m_wstrb   = lat_wstrb;
  assign m.m_awvalid = (state == WR) && aw_pend;
  assign m.m_wvalid  = (state == WR) && w_pend;
  assign m.m_bready  = (state == WRESP);
  assign m.m_arvalid = (state == RD_A);
  assign m.m_rready  = (state == RD_D);
  assign busy        = (state != IDLE);

  assign aw_hs = (state == WR) && aw_pend && m.m_awready;
  assign w_hs  = (state == WR) && w_pend && m.m_wready;
  assign ar_hs = (state == RD_A) && m.m_arready;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    advance = 1'b0;
    case (state)
      IDLE:    advance = arb_found;
      WR:      advance = (!aw_pend || aw_hs) && (!w_pend || w_hs);
      WRESP:   advance = m.m_bvalid;
      RD_A:    advance = ar_hs;
      RD_D:    advance = m.m_rvalid;
      DONE:    advance = 1'b1;
      default: advance = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (advance) begin
      case (state)
        IDLE:    state_next = req_we[arb_idx] ? WR : RD_A;
        WR:      state_next = WRESP;
        WRESP:   state_next = DONE;
        RD_A:    state_next = RD_D;
        RD_D:    state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else if (abort) begin
      state_next = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_resp   <= '0;
    end else begin
      case (state)
        IDLE: if (arb_found) begin
          grant      <= arb_idx;
          last_grant <= arb_idx;
          lat_addr   <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          lat_wdata  <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
          lat_wstrb  <= req_wstrb[int'(arb_idx)*STRB_W +: STRB_W];
          aw_pend    <= 1'b1;
          w_pend     <= 1'b1;
        end
        WR: begin
          if (aw_hs) aw_pend <= 1'b0;
          if (w_hs)  w_pend  <= 1'b0;
        end
        WRESP: if (m.m_bvalid) begin
          rsp_resp  <= m.m_bresp;
          rsp_rdata <= '0;
        end
        RD_D: if (m.m_rvalid) begin
          rsp_resp  <= m.m_rresp;
          rsp_rdata <= m.m_rdata;
        end
        default: ;
      endcase
      if (abort) begin
        rsp_resp  <= 2'b10;
        rsp_rdata <= '0;
      end
    end
  end

  always_comb begin
    req_done = '0;
    if (state == DONE) req_done[grant] = 1'b1;
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TXN_TIMEOUT + 1);

  logic [CNT_W-1:0] tcnt;
  logic             phase_active;

  assign phase_active = (state == WR) || (state == WRESP) || (state == RD_A) || (state == RD_D);
  // A handshake landing on the limit cycle wins over the abort.
  assign abort = phase_active && (tcnt == CNT_W'(TXN_TIMEOUT - 1)) && !advance;

  always_ff @(posedge clk) begin
    if (srst || (state_next != state)) tcnt <= '0;
    else if (phase_active)             tcnt <= tcnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) timeout_pulse <= 1'b0;
    else      timeout_pulse <= abort;
  end
`else
  assign abort         = 1'b0;
  assign timeout_pulse = 1'b0;
`endif
endmodule
